// File: rtl/ofc_pkg.sv
// -----------------------------------------------------------------------------
// ofc_pkg
// Shared definitions for the optimal-filter pulse-height block:
//   - ofc_state_t   : controller states (IDLE, ACC, DONE)
//   - DEFAULT_COEF  : coefficients loaded at reset for taps 0..3
//   - acc_width()   : accumulator width that cannot wrap for N_TAPS products
//   - default_coef(): reset coefficient for any tap index (0 beyond tap 3)
// -----------------------------------------------------------------------------
package ofc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } ofc_state_t;

    localparam int N_DEFAULT_COEF = 4;

    localparam logic signed [31:0] DEFAULT_COEF [N_DEFAULT_COEF] = '{
        32'sd140508,
        32'sd853540,
        32'sd290454,
        -32'sd420478
    };

    // Difference is DATA_W+1 bits signed; each product adds COEF_W bits and
    // summing N_TAPS of them needs clog2(N_TAPS) guard bits.
    function automatic int acc_width(input int data_w, input int coef_w,
                                     input int n_taps);
        return data_w + 1 + coef_w + $clog2(n_taps);
    endfunction

    // Sign-extended to 64 bits so callers can truncate or extend to COEF_W.
    function automatic logic signed [63:0] default_coef(input int idx);
        logic signed [31:0] c;
        c = 32'sd0;
        if (idx >= 0 && idx < N_DEFAULT_COEF) begin
            c = DEFAULT_COEF[idx[1:0]];
        end
        return {{32{c[31]}}, c};
    endfunction

endpackage

// File: rtl/ofc_mac.sv
// -----------------------------------------------------------------------------
// ofc_mac
// Signed subtract / multiply / accumulate datapath for one weighted tap per
// clock.
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset, clears the accumulator
//   clear    in   synchronous clear of the accumulator (start of pulse)
//   en       in   add (sample - pedestal) * coef to the accumulator
//   sample   in   DATA_W unsigned ADC sample
//   pedestal in   DATA_W unsigned pedestal
//   coef     in   COEF_W signed coefficient
//   acc_sum  out  ACC_W signed accumulator plus the current product; this is
//                 the value the accumulator takes when en is high
// -----------------------------------------------------------------------------
module ofc_mac #(
    parameter int DATA_W = 14,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 49
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic [DATA_W-1:0]        sample,
    input  logic [DATA_W-1:0]        pedestal,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc_sum
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DIFF_W + COEF_W;

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W-1:0]  acc_reg;

    // Zero-extend both unsigned operands so the difference is always exact.
    assign diff        = $signed({1'b0, sample}) - $signed({1'b0, pedestal});
    assign product     = diff * coef;
    assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign acc_sum     = acc_reg + product_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_sum;
        end
    end

endmodule

// File: rtl/ofc_filter.sv
// -----------------------------------------------------------------------------
// ofc_filter
// Optimal-filter pulse-height estimator. A trigger latches a pedestal, then
// N_TAPS consecutive samples are pedestal-subtracted, weighted by
// programmable coefficients and summed. The sum is scaled down by FRAC_BITS
// (floor) and saturated to a signed OUT_W result.
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   triggerIn   in   start of pulse
//   signal      in   DATA_W ADC sample, valid every cycle
//   ped_sel     in   0: pedestal = trigger-cycle sample, 1: ped_value
//   ped_value   in   DATA_W external pedestal
//   coef_wr     in   coefficient write strobe (honoured only while idle)
//   coef_addr   in   coefficient index
//   coef_data   in   COEF_W signed coefficient
//   busy        out  pulse in progress
//   out_valid   out  one-cycle result strobe
//   PulseHeight out  OUT_W signed result, held until the next strobe
//   sat         out  result was clipped
//   overrun_cnt out  dropped triggers/writes, saturating at 255
// Timing: trigger at T, samples T+1..T+N_TAPS weighted, out_valid at
// T+N_TAPS+1, next trigger accepted from T+N_TAPS+2.
// -----------------------------------------------------------------------------
module ofc_filter
    import ofc_pkg::*;
#(
    parameter int DATA_W    = 14,
    parameter int N_TAPS    = 4,
    parameter int COEF_W    = 32,
    parameter int FRAC_BITS = 20,
    parameter int OUT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       triggerIn,
    input  logic [DATA_W-1:0]          signal,
    input  logic                       ped_sel,
    input  logic [DATA_W-1:0]          ped_value,
    input  logic                       coef_wr,
    input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       busy,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    PulseHeight,
    output logic                       sat,
    output logic [7:0]                 overrun_cnt
);

    localparam int ADDR_W = $clog2(N_TAPS);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, N_TAPS);

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

    // Signed OUT_W limits expressed at accumulator width; ~max == min.
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    ofc_state_t               state_reg;
    ofc_state_t               state_next;
    logic [ADDR_W-1:0]        tap_reg;
    logic [DATA_W-1:0]        pedestal_reg;
    logic signed [COEF_W-1:0] coef_reg [N_TAPS];
    logic [N_TAPS-1:0]        coef_we;

    logic                     out_valid_reg;
    logic                     busy_reg;
    logic                     sat_reg;
    logic signed [OUT_W-1:0]  height_reg;
    logic [7:0]               overrun_reg;

    // Controller decodes
    logic trig_accept;
    logic mac_en;
    logic last_tap;
    logic drop;
    logic addr_ok;

    // Datapath
    logic [DATA_W-1:0]        ped_next;
    logic signed [COEF_W-1:0] coef_cur;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  clipped;
    logic                     clip;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        trig_accept = 1'b0;
        mac_en      = 1'b0;
        last_tap    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (triggerIn) begin
                    trig_accept = 1'b1;
                    state_next  = ACC;
                end
            end
            ACC: begin
                mac_en = 1'b1;
                if (tap_reg == LAST_TAP) begin
                    last_tap   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Anything arriving while a pulse is in flight is lost; a trigger and a
    // write in the same cycle count as a single overrun event.
    assign drop = (state_reg != IDLE) && (triggerIn || coef_wr);

    assign ped_next = ped_sel ? ped_value : signal;

    // ------------------------------------------------------------------
    // Coefficient bank. A write in the trigger cycle lands at the same edge
    // that enters ACC, so tap 0 already sees the new value.
    // ------------------------------------------------------------------
    generate
        if ((1 << ADDR_W) == N_TAPS) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (coef_addr < ADDR_W'(N_TAPS));
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_TAPS; gi++) begin : g_coef_we
            assign coef_we[gi] = coef_wr && (state_reg == IDLE) && addr_ok &&
                                 (coef_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef_reg[i] <= COEF_W'(default_coef(i));
            end
        end else begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (coef_we[i]) begin
                    coef_reg[i] <= coef_data;
                end
            end
        end
    end

    assign coef_cur = coef_reg[tap_reg];

    // ------------------------------------------------------------------
    // Multiply-accumulate
    // ------------------------------------------------------------------
    ofc_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (trig_accept),
        .en       (mac_en),
        .sample   (signal),
        .pedestal (pedestal_reg),
        .coef     (coef_cur),
        .acc_sum  (acc_sum)
    );

    // ------------------------------------------------------------------
    // Scaling and saturation. Taken from the sum that includes the final
    // tap, so the result can be registered at the edge that enters DONE and
    // be presented together with out_valid during the DONE cycle.
    // ------------------------------------------------------------------
    assign shifted = acc_sum >>> FRAC_BITS;

    always_comb begin
        clipped = shifted;
        clip    = 1'b0;
        if (shifted > OUT_MAX) begin
            clipped = OUT_MAX;
            clip    = 1'b1;
        end else if (shifted < OUT_MIN) begin
            clipped = OUT_MIN;
            clip    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            tap_reg       <= '0;
            pedestal_reg  <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            height_reg    <= '0;
            overrun_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= last_tap;
            busy_reg      <= (state_next != IDLE);

            if (trig_accept) begin
                tap_reg      <= '0;
                pedestal_reg <= ped_next;
            end else if (mac_en) begin
                tap_reg <= tap_reg + 1'b1;
            end

            if (last_tap) begin
                height_reg <= clipped[OUT_W-1:0];
                sat_reg    <= clip;
            end

            if (drop && (overrun_reg != 8'hFF)) begin
                overrun_reg <= overrun_reg + 8'd1;
            end
        end
    end

    assign busy        = busy_reg;
    assign out_valid   = out_valid_reg;
    assign PulseHeight = height_reg;
    assign sat         = sat_reg;
    assign overrun_cnt = overrun_reg;

endmodule

// File: tb/tb_ofc_filter.sv
// -----------------------------------------------------------------------------
// tb_ofc_filter
// Self-checking bench for ofc_filter with default parameters. A reference
// model tracks the pulse as "cycles since trigger" and computes the result as
// floor(sum((sample - pedestal) * coef) / 2^FRAC_BITS), clipped to 16 bits.
// -----------------------------------------------------------------------------
module tb_ofc_filter;

    localparam int DATA_W    = 14;
    localparam int N_TAPS    = 4;
    localparam int COEF_W    = 32;
    localparam int FRAC_BITS = 20;
    localparam int OUT_W     = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     triggerIn;
    logic [DATA_W-1:0]        signal;
    logic                     ped_sel;
    logic [DATA_W-1:0]        ped_value;
    logic                     coef_wr;
    logic [1:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     busy;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  PulseHeight;
    logic                     sat;
    logic [7:0]               overrun_cnt;

    always #5 clk = ~clk;

    ofc_filter #(
        .DATA_W    (DATA_W),
        .N_TAPS    (N_TAPS),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS),
        .OUT_W     (OUT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .triggerIn   (triggerIn),
        .signal      (signal),
        .ped_sel     (ped_sel),
        .ped_value   (ped_value),
        .coef_wr     (coef_wr),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .busy        (busy),
        .out_valid   (out_valid),
        .PulseHeight (PulseHeight),
        .sat         (sat),
        .overrun_cnt (overrun_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    int                      m_phase;   // 0 idle, k = cycles since trigger
    longint                  m_coef [N_TAPS];
    longint                  m_ped;
    longint                  m_acc;
    int                      m_ovr;
    logic signed [OUT_W-1:0] m_height;
    logic                    m_sat;

    // Observed and expected values for the cycle just driven
    logic                    o_valid, o_busy, o_sat;
    logic signed [OUT_W-1:0] o_height;
    logic [7:0]              o_ovr;
    logic                    e_valid, e_busy, e_busy_chk, e_sat;
    logic signed [OUT_W-1:0] e_height;
    int                      e_ovr;

    function automatic void model_reset();
        m_phase  = 0;
        m_coef   = '{140508, 853540, 290454, -420478};
        m_ped    = 0;
        m_acc    = 0;
        m_ovr    = 0;
        m_height = '0;
        m_sat    = 1'b0;
    endfunction

    function automatic void model_finish();
        longint sh;
        sh = m_acc >>> FRAC_BITS;
        if (sh > 32767) begin
            m_height = 16'sd32767;
            m_sat    = 1'b1;
        end else if (sh < -32768) begin
            m_height = -16'sd32768;
            m_sat    = 1'b1;
        end else begin
            m_height = 16'(sh);
            m_sat    = 1'b0;
        end
    endfunction

    // Drives one cycle of inputs, records DUT outputs and model expectations
    // for that cycle, advances the model and the clock.
    task automatic run_cycle(input bit trig, input int sig, input bit psel,
                             input int pval, input bit wr, input int addr,
                             input int data);
        triggerIn = trig;
        signal    = sig[DATA_W-1:0];
        ped_sel   = psel;
        ped_value = pval[DATA_W-1:0];
        coef_wr   = wr;
        coef_addr = addr[1:0];
        coef_data = data;

        o_valid  = out_valid;
        o_busy   = busy;
        o_height = PulseHeight;
        o_sat    = sat;
        o_ovr    = overrun_cnt;

        e_valid    = (m_phase == N_TAPS + 1);
        e_busy     = (m_phase != 0);
        e_busy_chk = (m_phase != N_TAPS + 1);
        e_height   = m_height;
        e_sat      = m_sat;
        e_ovr      = m_ovr;

        if (m_phase == 0) begin
            if (wr && addr < N_TAPS) m_coef[addr] = data;
            if (trig) begin
                m_ped   = psel ? pval : sig;
                m_acc   = 0;
                m_phase = 1;
            end
        end else begin
            if ((trig || wr) && m_ovr < 255) m_ovr++;
            if (m_phase <= N_TAPS) begin
                m_acc += (longint'(sig) - m_ped) * m_coef[m_phase-1];
                if (m_phase == N_TAPS) model_finish();
                m_phase++;
            end else begin
                m_phase = 0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        triggerIn = 1'b0;
        coef_wr   = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (PulseHeight !== 16'sd0) begin bad++; $display("FAIL reset_height got=%0d want=0", PulseHeight); end
        total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat); end
        total++; if (overrun_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovr got=%0d want=0", overrun_cnt); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        $display("reset: checked outputs at reset values");
    endtask

    // One isolated pulse with constant samples; result constants come from
    // hand calculation against the default or programmed coefficients.
    task automatic test_pulse(input string name, input bit psel, input int pval,
                              input int ped_sample, input int s,
                              input int exp_h, input bit exp_sat);
        for (int i = 0; i < N_TAPS + 4; i++) begin
            run_cycle(i == 0, (i == 0) ? ped_sample : ((i <= N_TAPS) ? s : 0),
                      psel, pval, 1'b0, 0, 0);
            total++; if (o_valid !== (i == N_TAPS + 1)) begin bad++; $display("FAIL %s_valid cyc=%0d got=%b want=%b", name, i, o_valid, (i == N_TAPS + 1)); end
            if (i != N_TAPS + 1) begin
                total++; if (o_busy !== (i >= 1 && i <= N_TAPS)) begin bad++; $display("FAIL %s_busy cyc=%0d got=%b", name, i, o_busy); end
            end
            if (i == N_TAPS + 1) begin
                total++; if (o_height !== 16'(exp_h)) begin bad++; $display("FAIL %s_height got=%0d want=%0d", name, o_height, exp_h); end
                total++; if (o_sat !== exp_sat) begin bad++; $display("FAIL %s_sat got=%b want=%b", name, o_sat, exp_sat); end
                total++; if (o_height !== e_height) begin bad++; $display("FAIL %s_model got=%0d want=%0d", name, o_height, e_height); end
                $display("%s: PulseHeight=%0d sat=%b", name, o_height, o_sat);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < N_TAPS; k++) begin
            run_cycle(1'b0, 0, 1'b0, 0, 1'b1, k, 2147483647);
        end
        test_pulse("saturation", 1'b0, 0, 0, 16383, 32767, 1'b1);
    endtask

    task automatic test_retrigger();
        int ovr0;
        ovr0 = int'(overrun_cnt);
        for (int i = 0; i < 16; i++) begin
            run_cycle(i < 12, (i == 0 || i == 6) ? 100 : 1100, 1'b0, 0, 1'b0, 0, 0);
            total++; if (o_valid !== (i == 5 || i == 11)) begin bad++; $display("FAIL retrig_valid cyc=%0d got=%b", i, o_valid); end
            if (i == 5 || i == 11) begin
                total++; if (o_height !== 16'sd823) begin bad++; $display("FAIL retrig_height cyc=%0d got=%0d want=823", i, o_height); end
            end
            if (i == 6) begin
                total++; if (int'(o_ovr) !== ovr0 + 5) begin bad++; $display("FAIL retrig_ovr_first got=%0d want=%0d", o_ovr, ovr0 + 5); end
            end
            total++; if (int'(o_ovr) !== e_ovr) begin bad++; $display("FAIL retrig_ovr cyc=%0d got=%0d want=%0d", i, o_ovr, e_ovr); end
        end
        $display("retrigger: overrun_cnt=%0d", overrun_cnt);
    endtask

    task automatic test_wr_in_acc();
        int ovr0;
        ovr0 = int'(overrun_cnt);
        for (int i = 0; i < N_TAPS + 3; i++) begin
            run_cycle(i == 0, (i == 0) ? 100 : 1100, 1'b0, 0, i == 2, 1, 0);
            if (i == N_TAPS + 1) begin
                total++; if (o_height !== 16'sd823) begin bad++; $display("FAIL wracc_height got=%0d want=823", o_height); end
            end
        end
        total++; if (int'(overrun_cnt) !== ovr0 + 1) begin bad++; $display("FAIL wracc_ovr got=%0d want=%0d", overrun_cnt, ovr0 + 1); end
        $display("wr_in_acc: overrun_cnt=%0d", overrun_cnt);
        test_pulse("after_dropped_wr", 1'b0, 0, 100, 1100, 823, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_cycle(1'b1, 100, 1'b0, 0, 1'b0, 0, 0);
        run_cycle(1'b0, 1100, 1'b0, 0, 1'b0, 0, 0);
        reset     = 1'b1;
        triggerIn = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (PulseHeight !== 16'sd0) begin bad++; $display("FAIL midrst_height got=%0d want=0", PulseHeight); end
        total++; if (overrun_cnt !== 8'd0) begin bad++; $display("FAIL midrst_ovr got=%0d want=0", overrun_cnt); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 1100, 1'b0, 0, 1'b0, 0, 0);
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid cyc=%0d got=%b want=0", i, o_valid); end
        end
        $display("reset_mid: pulse abandoned");
        test_pulse("after_reset", 1'b0, 0, 100, 1100, 823, 1'b0);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            int data;
            data = ($urandom_range(0, 7) == 0) ? int'($urandom)
                                               : $urandom_range(0, 4194303) - 2097152;
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 16383),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 16383),
                      $urandom_range(0, 4) == 0, $urandom_range(0, 3), data);
            total++; if (o_valid !== e_valid) begin bad++; errs++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", i, o_valid, e_valid); end
            total++; if (o_height !== e_height) begin bad++; errs++; $display("FAIL rand_height cyc=%0d got=%0d want=%0d", i, o_height, e_height); end
            total++; if (o_sat !== e_sat) begin bad++; errs++; $display("FAIL rand_sat cyc=%0d got=%b want=%b", i, o_sat, e_sat); end
            total++; if (int'(o_ovr) !== e_ovr) begin bad++; errs++; $display("FAIL rand_ovr cyc=%0d got=%0d want=%0d", i, o_ovr, e_ovr); end
            if (e_busy_chk) begin
                total++; if (o_busy !== e_busy) begin bad++; errs++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", i, o_busy, e_busy); end
            end
            if (e_valid) $display("random: cyc=%0d PulseHeight=%0d sat=%b", i, o_height, o_sat);
        end
        $display("random: done, overrun_cnt=%0d mismatches=%0d", overrun_cnt, errs);
    endtask

    initial begin
        reset     = 1'b1;
        triggerIn = 1'b0;
        signal    = '0;
        ped_sel   = 1'b0;
        ped_value = '0;
        coef_wr   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_pulse("ped_sample", 1'b0, 0, 100, 1100, 823, 1'b0);
        test_pulse("ped_external", 1'b1, 1100, 0, 0, -907, 1'b0);
        test_saturation();
        test_reset();
        test_retrigger();
        test_wr_in_acc();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
